omr_grader_seq: RTL and testbench
=================================

# omr_grader_seq

Sequential, parametrised OMR sheet grader. It loads an answer key of NUM_Q one-hot questions once, then grades any number of student sheets, one answer per cycle over a valid/ready stream. Each answer is classified as correct, wrong, blank or invalid (multi-mark), and the block produces a clamped score with optional negative marking. It replaces the fixed 10-question, 4-option combinational grader.

## Interface
- NUM_Q, 10: questions per sheet, ≥1.
- NUM_OPT, 4: options per question, bit i set = option i marked.
- POS_MARK, 1: points per correct answer, ≥1.
- NEG_MARK, 1: points deducted per wrong/invalid answer when neg_en=1.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- key_load  in  1  pulse: enter key-load phase (honoured in IDLE/DONE only).
- key_valid  in  1  key entry present.
- key_data  in  NUM_OPT  key entry, question 0 first.
- key_ready  out  1  high in KEY state.
- start  in  1  pulse: begin grading a sheet (honoured in IDLE/DONE when key_loaded=1).
- neg_en  in  1  negative marking enable, sampled on accepted start.
- ans_valid  in  1  student answer present.
- ans_data  in  NUM_OPT  student answer, question 0 first.
- ans_ready  out  1  high in GRADE state.
- key_loaded  out  1  full key captured.
- busy  out  1  state is KEY or GRADE.
- done  out  1  state is DONE; results valid and held.
- score  out  SCORE_W=$clog2(NUM_Q*POS_MARK+1)  clamped score.
- n_correct, n_wrong, n_blank, n_invalid  out  CNT_W=$clog2(NUM_Q+1) each  class counts.

## Operation
- FSM states: IDLE, KEY, GRADE, DONE.
- IDLE/DONE + key_load → KEY. key_load has priority over start in the same cycle.
- KEY: each key_valid&&key_ready writes key[idx], idx++. The NUM_Q-th write → IDLE with key_loaded=1. Entering KEY clears key_loaded and all results.
- IDLE/DONE + start + key_loaded → GRADE. Counters, accumulator and question index clear; neg_en is latched. start with key_loaded=0 is ignored.
- GRADE: an answer is accepted on ans_valid&&ans_ready and classified against key[idx]:
  - blank: ans==0.
  - invalid: popcount(ans)>1.
  - correct: ans==key[idx].
  - wrong: otherwise.
  - Void key entry (key[idx] not one-hot): the answer counts as correct regardless of ans.
- Accumulator: signed, width SCORE_W+CNT_W+$clog2(NEG_MARK+1)+1. It adds POS_MARK on correct. It subtracts NEG_MARK on wrong or invalid when the latched neg_en=1. Blank never changes the score.
- score = max(0, accumulator), registered. A negative running total is allowed and only the output is clamped.
- The NUM_Q-th accepted answer → DONE. Results hold until the next accepted start or key_load.
- key_valid outside KEY and ans_valid outside GRADE are ignored. There is no back-pressure other than ready.
- Invariant in DONE: n_correct+n_wrong+n_blank+n_invalid == NUM_Q.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE. key_loaded=0, key_ready=0, ans_ready=0, busy=0, done=0, score=0, all counts=0. Key storage is cleared to 0.
- start/key_load accepted at edge N: busy=1 and the matching ready=1 from cycle N+1.
- Counts and score reflect an accepted answer one cycle after the accepting edge.
- Full-rate grading takes NUM_Q cycles in GRADE. done=1 the cycle after the last accept, with final counts and score valid in that same cycle.
- ans_ready drops in the cycle after the last accept. No answer is accepted in DONE.
- reset_n low mid-KEY or mid-GRADE: immediate return to reset values. The key is lost and must be reloaded.

## Structure
- Shared package omr_pkg:
  - state enum (IDLE, KEY, GRADE, DONE);
  - answer-class enum (CORRECT, WRONG, BLANK, INVALID);
  - width helper functions for SCORE_W and CNT_W.
- One sub-module, omr_classify: combinational (key entry, answer) → class, including popcount and the void-key rule. It is reused by the later multi-channel grader.
- Top level holds the FSM, key register array, index counter, class counters and score accumulator.

## Test plan
- Load key Q0..Q9 = 1000,1000,1000,0001,0100,0100,0100,0010,0010,0001. Grade an identical sheet → done after 10 accepts, score=10, n_correct=10, other counts 0.
- Same key, answers Q0..Q9 = 1000,1000,1000,0001,0010,0100,0010,0010,0010,0001:
  - neg_en=1 → n_correct=8, n_wrong=2, score=6.
  - neg_en=0 → score=8.
- Sheet of all 0000 → n_blank=10, score=0. Sheet with 0101 at Q5 and other answers wrong, neg_en=1 → n_invalid=1, n_wrong=9, score clamps to 0.
- ans_valid toggled every other cycle with key_valid spuriously high during GRADE → same results as full rate, key unchanged. start while key_loaded=0 → no state change.
- Assert reset_n low after 5 answers → all outputs at reset values, key_loaded=0. A following start is ignored until the key is reloaded.
- Two back-to-back sheets with start asserted in DONE → second results independent of the first. key_load and start in the same cycle → KEY is entered.

Source files
------------

// File: rtl/omr_pkg.sv
// Shared types and width helpers for the OMR grader family.
package omr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      KEY,
      GRADE,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      CORRECT,
      WRONG,
      BLANK,
      INVALID
   } cls_t;

   // Width of a score able to hold num_q*pos_mark.
   function automatic int unsigned score_width(input int unsigned num_q,
                                               input int unsigned pos_mark);
      return $clog2(num_q * pos_mark + 1);
   endfunction

   // Width of a counter able to hold num_q.
   function automatic int unsigned cnt_width(input int unsigned num_q);
      return $clog2(num_q + 1);
   endfunction

endpackage

// File: rtl/omr_classify.sv
// Combinational classification of one answer against its key entry.
module omr_classify
   import omr_pkg::*;
#(
   parameter int unsigned NUM_OPT = 4
) (
   input  logic [NUM_OPT-1:0] key_entry,
   input  logic [NUM_OPT-1:0] ans,
   output cls_t               cls
);

   localparam int unsigned POP_W = $clog2(NUM_OPT + 1);

   logic [POP_W-1:0] key_pop;
   logic [POP_W-1:0] ans_pop;

   // Popcounts of key and answer, then class; a non-one-hot key voids the question.
   always_comb begin
      key_pop = '0;
      ans_pop = '0;
      for (int unsigned i = 0; i < NUM_OPT; i++) begin
         key_pop = key_pop + POP_W'(key_entry[i]);
         ans_pop = ans_pop + POP_W'(ans[i]);
      end
      cls = WRONG;
      if (key_pop != POP_W'(1))
         cls = CORRECT;
      else if (ans == '0)
         cls = BLANK;
      else if (ans_pop > POP_W'(1))
         cls = INVALID;
      else if (ans == key_entry)
         cls = CORRECT;
   end

endmodule

// File: rtl/omr_grader_seq.sv
// Sequential OMR grader: loads a one-hot answer key, then grades streamed sheets.
module omr_grader_seq
   import omr_pkg::*;
#(
   parameter  int unsigned NUM_Q    = 10,
   parameter  int unsigned NUM_OPT  = 4,
   parameter  int unsigned POS_MARK = 1,
   parameter  int unsigned NEG_MARK = 1,
   localparam int unsigned SCORE_W  = score_width(NUM_Q, POS_MARK),
   localparam int unsigned CNT_W    = cnt_width(NUM_Q)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               key_load,
   input  logic               key_valid,
   input  logic [NUM_OPT-1:0] key_data,
   output logic               key_ready,
   input  logic               start,
   input  logic               neg_en,
   input  logic               ans_valid,
   input  logic [NUM_OPT-1:0] ans_data,
   output logic               ans_ready,
   output logic               key_loaded,
   output logic               busy,
   output logic               done,
   output logic [SCORE_W-1:0] score,
   output logic [CNT_W-1:0]   n_correct,
   output logic [CNT_W-1:0]   n_wrong,
   output logic [CNT_W-1:0]   n_blank,
   output logic [CNT_W-1:0]   n_invalid
);

   localparam int unsigned ACC_W = SCORE_W + CNT_W + $clog2(NEG_MARK + 1) + 1;
   localparam int unsigned IDX_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
   localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_Q - 1);
   localparam logic signed [ACC_W-1:0] POS_INC  = ACC_W'(POS_MARK);
   localparam logic signed [ACC_W-1:0] NEG_DEC  = ACC_W'(NEG_MARK);

   state_t                    state;
   logic [IDX_W-1:0]          idx;
   logic [NUM_OPT-1:0]        key_mem [NUM_Q];
   logic                      neg_lat;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   acc_next;
   logic [SCORE_W-1:0]        score_next;
   cls_t                      cls;

   omr_classify #(.NUM_OPT(NUM_OPT)) u_classify (
      .key_entry (key_mem[idx]),
      .ans       (ans_data),
      .cls       (cls)
   );

   // Next accumulator value for the answer at the port, and its clamped score.
   always_comb begin
      acc_next = acc;
      if (cls == CORRECT)
         acc_next = acc + POS_INC;
      else if ((cls == WRONG || cls == INVALID) && neg_lat)
         acc_next = acc - NEG_DEC;
      score_next = acc_next[ACC_W-1] ? '0 : acc_next[SCORE_W-1:0];
   end

   // Control FSM with registered handshake/status outputs, key store and result counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         idx        <= '0;
         neg_lat    <= 1'b0;
         acc        <= '0;
         key_ready  <= 1'b0;
         ans_ready  <= 1'b0;
         key_loaded <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         score      <= '0;
         n_correct  <= '0;
         n_wrong    <= '0;
         n_blank    <= '0;
         n_invalid  <= '0;
         for (int unsigned i = 0; i < NUM_Q; i++)
            key_mem[i] <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (key_load) begin
                  state      <= KEY;
                  idx        <= '0;
                  key_ready  <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  key_loaded <= 1'b0;
                  acc        <= '0;
                  score      <= '0;
                  n_correct  <= '0;
                  n_wrong    <= '0;
                  n_blank    <= '0;
                  n_invalid  <= '0;
               end else if (start && key_loaded) begin
                  state      <= GRADE;
                  idx        <= '0;
                  neg_lat    <= neg_en;
                  ans_ready  <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  acc        <= '0;
                  score      <= '0;
                  n_correct  <= '0;
                  n_wrong    <= '0;
                  n_blank    <= '0;
                  n_invalid  <= '0;
               end
            end
            KEY: begin
               if (key_valid && key_ready) begin
                  key_mem[idx] <= key_data;
                  if (idx == LAST_IDX) begin
                     state      <= IDLE;
                     idx        <= '0;
                     key_ready  <= 1'b0;
                     busy       <= 1'b0;
                     key_loaded <= 1'b1;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            GRADE: begin
               if (ans_valid && ans_ready) begin
                  acc   <= acc_next;
                  score <= score_next;
                  unique case (cls)
                     CORRECT: n_correct <= n_correct + CNT_W'(1);
                     WRONG:   n_wrong   <= n_wrong + CNT_W'(1);
                     BLANK:   n_blank   <= n_blank + CNT_W'(1);
                     INVALID: n_invalid <= n_invalid + CNT_W'(1);
                  endcase
                  if (idx == LAST_IDX) begin
                     state     <= DONE;
                     idx       <= '0;
                     ans_ready <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_omr_grader_seq.sv
// Self-checking bench for omr_grader_seq against a rule-level scoring model.
module tb_omr_grader_seq;

   localparam int unsigned NUM_Q    = 10;
   localparam int unsigned NUM_OPT  = 4;
   localparam int unsigned POS_MARK = 1;
   localparam int unsigned NEG_MARK = 1;
   localparam int unsigned SCORE_W  = $clog2(NUM_Q * POS_MARK + 1);
   localparam int unsigned CNT_W    = $clog2(NUM_Q + 1);
   localparam int unsigned RES_W    = 1 + SCORE_W + 4 * CNT_W;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               key_load = 1'b0;
   logic               key_valid = 1'b0;
   logic [NUM_OPT-1:0] key_data = '0;
   logic               key_ready;
   logic               start = 1'b0;
   logic               neg_en = 1'b0;
   logic               ans_valid = 1'b0;
   logic [NUM_OPT-1:0] ans_data = '0;
   logic               ans_ready;
   logic               key_loaded;
   logic               busy;
   logic               done;
   logic [SCORE_W-1:0] score;
   logic [CNT_W-1:0]   n_correct, n_wrong, n_blank, n_invalid;

   omr_grader_seq #(
      .NUM_Q    (NUM_Q),
      .NUM_OPT  (NUM_OPT),
      .POS_MARK (POS_MARK),
      .NEG_MARK (NEG_MARK)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_load   (key_load),
      .key_valid  (key_valid),
      .key_data   (key_data),
      .key_ready  (key_ready),
      .start      (start),
      .neg_en     (neg_en),
      .ans_valid  (ans_valid),
      .ans_data   (ans_data),
      .ans_ready  (ans_ready),
      .key_loaded (key_loaded),
      .busy       (busy),
      .done       (done),
      .score      (score),
      .n_correct  (n_correct),
      .n_wrong    (n_wrong),
      .n_blank    (n_blank),
      .n_invalid  (n_invalid)
   );

   always #5 clk = ~clk;

   int unsigned        n_pass = 0;
   int unsigned        n_total = 0;
   logic [NUM_OPT-1:0] key_m [NUM_Q];
   logic [NUM_OPT-1:0] ans_m [NUM_Q];
   logic [RES_W-1:0]   exp_res;
   logic [RES_W-1:0]   obs_res;
   int                 grade_cycles;

   assign obs_res = {done, score, n_correct, n_wrong, n_blank, n_invalid};

   // Expected {done, score, counts} straight from the grading rules.
   task automatic compute_expected(input bit neg);
      int c, w, b, inv, s;
      c = 0; w = 0; b = 0; inv = 0;
      for (int q = 0; q < NUM_Q; q++) begin
         if ($countones(key_m[q]) != 1) c++;
         else if (ans_m[q] == '0) b++;
         else if ($countones(ans_m[q]) > 1) inv++;
         else if (ans_m[q] == key_m[q]) c++;
         else w++;
      end
      s = c * int'(POS_MARK) - (neg ? (w + inv) * int'(NEG_MARK) : 0);
      if (s < 0) s = 0;
      exp_res = {1'b1, SCORE_W'(s), CNT_W'(c), CNT_W'(w), CNT_W'(b), CNT_W'(inv)};
   endtask

   task automatic set_plan_key();
      logic [NUM_OPT-1:0] k [NUM_Q];
      k = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0100,
            4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0001};
      for (int q = 0; q < NUM_Q; q++) key_m[q] = k[q];
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Pulse key_load then stream key_m at full rate.
   task automatic load_key();
      key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      for (int q = 0; q < NUM_Q; q++) begin
         key_valid = 1'b1;
         key_data  = key_m[q];
         @(negedge clk);
      end
      key_valid = 1'b0;
      n_total++;
      if (key_loaded !== 1'b1 || busy !== 1'b0)
         $display("FAIL key_load_end: key_loaded=%b busy=%b required 1/0", key_loaded, busy);
      else n_pass++;
   endtask

   // Start a sheet and stream ans_m; checks handshake timing and the cycle budget.
   task automatic grade(input bit neg, input bit throttle, input bit spurious);
      int  i;
      bit  acc_now;
      start  = 1'b1;
      neg_en = neg;
      @(negedge clk);
      start  = 1'b0;
      neg_en = 1'($urandom);
      n_total++;
      if (busy !== 1'b1 || ans_ready !== 1'b1 || done !== 1'b0)
         $display("FAIL start_handshake: busy=%b ans_ready=%b done=%b required 1/1/0", busy, ans_ready, done);
      else n_pass++;
      i = 0;
      grade_cycles = 0;
      while (i < NUM_Q && grade_cycles < 4 * NUM_Q + 20) begin
         ans_valid = throttle ? (grade_cycles % 2 == 0) : 1'b1;
         ans_data  = ans_valid ? ans_m[i] : NUM_OPT'($urandom);
         key_valid = spurious;
         key_data  = NUM_OPT'($urandom);
         acc_now   = ans_valid && ans_ready;
         @(negedge clk);
         grade_cycles++;
         if (acc_now) i++;
      end
      ans_valid = 1'b0;
      key_valid = 1'b0;
      n_total++;
      if (i < NUM_Q)
         $display("FAIL grade_timeout: accepted %0d answers, required %0d", i, NUM_Q);
      else n_pass++;
      n_total++;
      if (ans_ready !== 1'b0 || busy !== 1'b0)
         $display("FAIL grade_end_ready: ans_ready=%b busy=%b required 0/0", ans_ready, busy);
      else n_pass++;
   endtask

   task automatic test_reset();
      do_reset();
      n_total++;
      if (obs_res !== '0)
         $display("FAIL reset_results: got %h required 0", obs_res);
      else n_pass++;
      n_total++;
      if ({key_ready, ans_ready, busy, key_loaded} !== 4'b0)
         $display("FAIL reset_flags: got %b required 0000", {key_ready, ans_ready, busy, key_loaded});
      else n_pass++;
   endtask

   task automatic test_start_no_key();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      n_total++;
      if ({busy, ans_ready, done, key_ready} !== 4'b0)
         $display("FAIL start_no_key: busy/ans_ready/done/key_ready=%b required 0000",
                  {busy, ans_ready, done, key_ready});
      else n_pass++;
   endtask

   task automatic test_identical();
      set_plan_key();
      load_key();
      for (int q = 0; q < NUM_Q; q++) ans_m[q] = key_m[q];
      grade(1'b1, 1'b0, 1'b0);
      n_total++;
      if (grade_cycles != NUM_Q)
         $display("FAIL identical_cycles: got %0d required %0d", grade_cycles, NUM_Q);
      else n_pass++;
      compute_expected(1'b1);
      n_total++;
      if (obs_res !== exp_res)
         $display("FAIL identical: got %h required %h", obs_res, exp_res);
      else n_pass++;
   endtask

   task automatic set_mixed_answers();
      for (int q = 0; q < NUM_Q; q++) ans_m[q] = key_m[q];
      ans_m[4] = 4'b0010;
      ans_m[6] = 4'b0010;
   endtask

   task automatic test_mixed();
      set_mixed_answers();
      grade(1'b1, 1'b0, 1'b0);
      compute_expected(1'b1);
      n_total++;
      if (obs_res !== exp_res)
         $display("FAIL mixed_neg: got %h required %h", obs_res, exp_res);
      else n_pass++;
      grade(1'b0, 1'b0, 1'b0);
      compute_expected(1'b0);
      n_total++;
      if (obs_res !== exp_res)
         $display("FAIL mixed_noneg: got %h required %h", obs_res, exp_res);
      else n_pass++;
   endtask

   task automatic test_blank_invalid();
      for (int q = 0; q < NUM_Q; q++) ans_m[q] = '0;
      grade(1'b1, 1'b0, 1'b0);
      compute_expected(1'b1);
      n_total++;
      if (obs_res !== exp_res)
         $display("FAIL all_blank: got %h required %h", obs_res, exp_res);
      else n_pass++;
      for (int q = 0; q < NUM_Q; q++) ans_m[q] = {key_m[q][NUM_OPT-2:0], key_m[q][NUM_OPT-1]};
      ans_m[5] = 4'b0101;
      grade(1'b1, 1'b0, 1'b0);
      compute_expected(1'b1);
      n_total++;
      if (obs_res !== exp_res)
         $display("FAIL invalid_clamp: got %h required %h", obs_res, exp_res);
      else n_pass++;
   endtask

   task automatic test_throttle();
      set_mixed_answers();
      grade(1'b1, 1'b1, 1'b1);
      compute_expected(1'b1);
      n_total++;
      if (obs_res !== exp_res)
         $display("FAIL throttle: got %h required %h", obs_res, exp_res);
      else n_pass++;
      for (int q = 0; q < NUM_Q; q++) ans_m[q] = key_m[q];
      grade(1'b0, 1'b0, 1'b0);
      compute_expected(1'b0);
      n_total++;
      if (obs_res !== exp_res)
         $display("FAIL key_kept: got %h required %h", obs_res, exp_res);
      else n_pass++;
   endtask

   task automatic test_reset_mid_grade();
      int sum;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int q = 0; q < 5; q++) begin
         ans_valid = 1'b1;
         ans_data  = ans_m[q];
         @(negedge clk);
      end
      ans_valid = 1'b0;
      sum = int'(n_correct) + int'(n_wrong) + int'(n_blank) + int'(n_invalid);
      n_total++;
      if (sum != 5 || busy !== 1'b1)
         $display("FAIL partial_counts: sum=%0d busy=%b required 5/1", sum, busy);
      else n_pass++;
      #2 reset_n = 1'b0;
      #1;
      n_total++;
      if (obs_res !== '0 || {key_ready, ans_ready, busy, key_loaded} !== 4'b0)
         $display("FAIL reset_mid_grade: res=%h flags=%b required 0/0000",
                  obs_res, {key_ready, ans_ready, busy, key_loaded});
      else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_total++;
      if ({busy, ans_ready, key_loaded} !== 3'b0)
         $display("FAIL start_after_reset: busy/ans_ready/key_loaded=%b required 000",
                  {busy, ans_ready, key_loaded});
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      bit neg;
      set_plan_key();
      load_key();
      for (int s = 0; s < 2; s++) begin
         for (int q = 0; q < NUM_Q; q++) ans_m[q] = NUM_OPT'($urandom);
         neg = 1'($urandom);
         grade(neg, 1'b0, 1'b0);
         compute_expected(neg);
         n_total++;
         if (obs_res !== exp_res)
            $display("FAIL back_to_back_%0d: got %h required %h", s, obs_res, exp_res);
         else n_pass++;
      end
   endtask

   task automatic test_priority();
      key_load = 1'b1;
      start    = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      start    = 1'b0;
      n_total++;
      if ({key_ready, ans_ready, key_loaded, done} !== 4'b1000 || obs_res !== '0)
         $display("FAIL key_load_priority: flags=%b res=%h required 1000/0",
                  {key_ready, ans_ready, key_loaded, done}, obs_res);
      else n_pass++;
      for (int q = 0; q < NUM_Q; q++) begin
         key_m[q]  = NUM_OPT'(1) << $urandom_range(NUM_OPT - 1);
         key_valid = 1'b1;
         key_data  = key_m[q];
         @(negedge clk);
      end
      key_valid = 1'b0;
      for (int q = 0; q < NUM_Q; q++) ans_m[q] = key_m[q];
      grade(1'b1, 1'b0, 1'b0);
      compute_expected(1'b1);
      n_total++;
      if (obs_res !== exp_res)
         $display("FAIL after_priority: got %h required %h", obs_res, exp_res);
      else n_pass++;
   endtask

   task automatic test_random();
      bit neg;
      for (int r = 0; r < 6; r++) begin
         for (int q = 0; q < NUM_Q; q++) begin
            if ($urandom_range(4) == 0) key_m[q] = NUM_OPT'($urandom);
            else key_m[q] = NUM_OPT'(1) << $urandom_range(NUM_OPT - 1);
            case ($urandom_range(3))
               0:       ans_m[q] = key_m[q];
               1:       ans_m[q] = NUM_OPT'(1) << $urandom_range(NUM_OPT - 1);
               default: ans_m[q] = NUM_OPT'($urandom);
            endcase
         end
         load_key();
         neg = 1'($urandom);
         grade(neg, 1'($urandom), 1'($urandom));
         compute_expected(neg);
         n_total++;
         if (obs_res !== exp_res)
            $display("FAIL random_%0d: got %h required %h", r, obs_res, exp_res);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_start_no_key();
      test_identical();
      test_mixed();
      test_blank_invalid();
      test_throttle();
      test_reset_mid_grade();
      test_back_to_back();
      test_priority();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end

endmodule
